rgb_pwm_fader: RTL and testbench
================================

// Module: rgb_pwm_fader
// PURPOSE
// Downstream stage of the colour-cycling FSM: takes its three on/off colour bits and drives the
// board RGB LED pins. Each channel ramps linearly between off and full brightness, so colour
// changes crossfade instead of snapping. Output is PWM on active-low pins by default.
// PARAMETERS
// PWM_BITS       8     width of duty and PWM counters; MAX = 2**PWM_BITS-1
// STEP_INTERVAL  7812  clk cycles per duty step (full 0->MAX ramp ~= 2.0M cycles at 12 MHz)
// ACTIVE_LOW     1     1: LED pin low = lit; 0: pin high = lit
// PORTS
// clk        in   1  system clock (12 MHz)
// rst_n      in   1  asynchronous, active-low reset
// enable     in   1  1 = run; 0 = freeze ramps and blank all LEDs
// red_in     in   1  red target from colour FSM (1 = full, 0 = off)
// green_in   in   1  green target
// blue_in    in   1  blue target
// led_red    out  1  PWM pin, polarity per ACTIVE_LOW
// led_green  out  1  PWM pin
// led_blue   out  1  PWM pin
// busy       out  1  1 while any channel duty != its target
// BEHAVIOUR
// - Reset (rst_n=0, async): in_q=0, all duty=0, step_cnt=0, pwm_cnt=0, busy=0,
//   led_* = inactive level (1 if ACTIVE_LOW). Takes effect without a clock edge.
// - Input register: {red,green,blue}_in sampled into in_q each cycle (1-cycle latency).
//   target_c = in_q_c ? MAX : 0.
// - Step timer: step_cnt counts 0..STEP_INTERVAL-1, wraps to 0. tick=1 when
//   step_cnt==STEP_INTERVAL-1.
// - Per-channel FSM, 4 states (separate instance per channel):
//   OFF (duty=0, target=0)    -> RISE when target=MAX
//   RISE                      -> on tick: duty+1; -> ON when duty reaches MAX;
//                                -> FALL when target becomes 0 (reverse from current duty)
//   ON (duty=MAX, target=MAX) -> FALL when target=0
//   FALL                      -> on tick: duty-1; -> OFF when duty reaches 0;
//                                -> RISE when target becomes MAX
//   Duty never overshoots: no increment at MAX, no decrement at 0.
//   Direction reverses at the next tick, with no hold step.
// - Latency: target edge -> first duty change = 1 cycle (in_q) + wait for next tick.
// - PWM: pwm_cnt free-runs 0..MAX, wraps to 0. It is shared by all channels.
//   lit_c = (duty_c==MAX) | (pwm_cnt < duty_c). duty=0 means never lit. duty=MAX means always lit.
//   Otherwise lit for exactly duty_c cycles per 2**PWM_BITS-cycle period.
// - Outputs are registered: led_c <= ACTIVE_LOW ? ~lit_c : lit_c (1 cycle after lit_c is computed).
// - busy is registered: OR over channels of (duty_c != target_c).
// - enable=0: step_cnt, pwm_cnt, duty and FSM states hold. in_q keeps sampling.
//   led_* go inactive on the next edge. busy holds its computed value.
//   enable 0->1: resume from the held values. No restart.
// - Simultaneous tick and target reversal in the same cycle: the step follows the new direction.
// - Reset mid-ramp: all duties return to 0 and the LEDs blank immediately.
// TESTING (bench parameters: PWM_BITS=4, STEP_INTERVAL=4, ACTIVE_LOW=1 unless noted)
// 1 Reset: rst_n=0 mid-clock -> led_*=1 and busy=0 before the next edge.
//   Release with inputs 0 -> led_*=1 and busy=0 for 200 cycles.
// 2 Ramp up: red_in 0->1 -> busy=1 within 2 cycles; duty_red reaches 15 after exactly 15 ticks
//   (60 cycles +/- tick phase); then led_red=0 constantly and busy=0.
// 3 Reversal: drop red_in when duty_red=7 -> duty 7,6,...,0 on successive ticks,
//   never 8 and never below 0; FSM ends in OFF; led_red=1 constantly.
// 4 Duty accuracy (STEP_INTERVAL=16, aligned to the PWM period): for each period, count cycles
//   with led_green=0 -> equals that period's duty (0,1,...,15), except duty 15 gives 16.
// 5 Enable gating: enable=0 during a blue ramp at duty 9 -> led_*=1 next cycle; duty stays 9
//   for 100 cycles; enable=1 -> ramp resumes at 10.
// 6 All channels plus ACTIVE_LOW=0: inputs 3'b111 -> all three reach MAX on the same tick,
//   led_*=1 constantly; then inputs 3'b000 -> all fall in lockstep to 0.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: crossfades three on/off colour bits into PWM-driven RGB LED pins.
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_INTERVAL = 7812,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic led_red,
  output logic led_green,
  output logic led_blue,
  output logic busy
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int SW = STEP_INTERVAL > 1 ? $clog2(STEP_INTERVAL) : 1;
  typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;
  logic [2:0] in_q;
  logic [SW-1:0] step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic tick;
  logic [2:0] lit;
  logic [2:0] mis;
  logic [2:0] led_q;
  assign tick = enable && step_cnt == SW'(STEP_INTERVAL - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_q <= '0;
      step_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      in_q <= {red_in, green_in, blue_in};
      if (enable) begin
        step_cnt <= tick ? '0 : step_cnt + SW'(1);
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  // bit 2 = red, bit 1 = green, bit 0 = blue
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic tgt;
    state_t state, state_nxt;
    logic [PWM_BITS-1:0] duty, duty_nxt;
    assign tgt = in_q[i];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state <= OFF;
        duty <= '0;
      end else begin
        state <= state_nxt;
        duty <= duty_nxt;
      end
    // step direction comes from the current target, so a reversal coinciding with a tick steps the new way
    always_comb begin
      duty_nxt = !tick ? duty
               : tgt ? (duty == MAX ? duty : duty + PWM_BITS'(1))
               : (duty == '0 ? duty : duty - PWM_BITS'(1));
      state_nxt = state;
      if (enable)
        case (state)
          OFF:     state_nxt = tgt ? RISE : OFF;
          RISE:    state_nxt = !tgt ? FALL : duty_nxt == MAX ? ON : RISE;
          ON:      state_nxt = !tgt ? FALL : ON;
          default: state_nxt = tgt ? RISE : duty_nxt == '0 ? OFF : FALL;
        endcase
    end
    always_comb begin
      lit[i] = duty == MAX || pwm_cnt < duty;
      mis[i] = duty != (tgt ? MAX : '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      led_q <= {3{ACTIVE_LOW}};
      busy <= 1'b0;
    end else begin
      led_q <= enable ? (ACTIVE_LOW ? ~lit : lit) : {3{ACTIVE_LOW}};
      busy <= |mis;
    end
  assign {led_red, led_green, led_blue} = led_q;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: three DUT variants against a cycle-level arithmetic model of duty, PWM and LEDs.
module tb_rgb_pwm_fader;
  localparam int MAXV = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic red_in = 1'b0;
  logic green_in = 1'b0;
  logic blue_in = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int tgt_of(input bit on);
    return on ? MAXV : 0;
  endfunction
  // instance 0: base config, 1: slow steps aligned to the PWM period, 2: active-high pins
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int SI = g == 1 ? 16 : 4;
    localparam bit AL = g != 2;
    logic [2:0] led;
    logic bsy;
    int m_duty [3];
    int m_cyc, m_ph;
    bit [2:0] m_inq, m_led;
    bit m_busy;
    rgb_pwm_fader #(.PWM_BITS(4), .STEP_INTERVAL(SI), .ACTIVE_LOW(AL)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .led_red(led[2]), .led_green(led[1]), .led_blue(led[0]), .busy(bsy)
    );
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        m_inq <= '0;
        m_cyc <= 0;
        m_ph <= 0;
        m_busy <= 1'b0;
        m_led <= {3{AL}};
        for (int c = 0; c < 3; c++) m_duty[c] <= 0;
      end else begin
        m_inq <= {red_in, green_in, blue_in};
        m_busy <= m_duty[0] != tgt_of(m_inq[0]) || m_duty[1] != tgt_of(m_inq[1]) || m_duty[2] != tgt_of(m_inq[2]);
        for (int c = 0; c < 3; c++) begin
          m_led[c] <= enable ? AL ^ (m_duty[c] == MAXV || m_ph < m_duty[c]) : AL;
          if (enable && m_cyc % SI == SI - 1)
            m_duty[c] <= m_inq[c] ? (m_duty[c] < MAXV ? m_duty[c] + 1 : MAXV) : (m_duty[c] > 0 ? m_duty[c] - 1 : 0);
        end
        if (enable) begin
          m_cyc <= m_cyc + 1;
          m_ph <= (m_ph + 1) % (MAXV + 1);
        end
      end
    always @(negedge clk) begin
      chk($sformatf("i%0d led", g), int'(led), int'(m_led));
      chk($sformatf("i%0d busy", g), int'(bsy), int'(m_busy));
      chk($sformatf("i%0d duty_r", g), int'(u_dut.g_ch[2].duty), m_duty[2]);
      chk($sformatf("i%0d duty_g", g), int'(u_dut.g_ch[1].duty), m_duty[1]);
      chk($sformatf("i%0d duty_b", g), int'(u_dut.g_ch[0].duty), m_duty[0]);
    end
  end
  task automatic wait_duty(input int ch, input int val, input int lim);
    int n = 0;
    while (g_inst[0].m_duty[ch] != val && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk($sformatf("timeout ch%0d", ch), g_inst[0].m_duty[ch], val);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst led0", int'(g_inst[0].led), 7);
    chk("arst led2", int'(g_inst[2].led), 0);
    chk("arst busy0", int'(g_inst[0].bsy), 0);
    chk("arst duty_r", int'(g_inst[0].u_dut.g_ch[2].duty), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    red_in = 1'b1;
    wait_duty(2, MAXV, 100);
    repeat (30) @(negedge clk);
    red_in = 1'b0;
    wait_duty(2, 0, 100);
    red_in = 1'b1;
    wait_duty(2, 7, 60);
    red_in = 1'b0;
    wait_duty(2, 0, 60);
    repeat (3) @(negedge clk);
    chk("state off", int'(g_inst[0].u_dut.g_ch[2].state), 0);
    green_in = 1'b1;
    repeat (400) @(negedge clk);
    blue_in = 1'b1;
    wait_duty(0, 9, 60);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("hold duty_b", int'(g_inst[0].u_dut.g_ch[0].duty), 9);
    enable = 1'b1;
    wait_duty(0, 10, 10);
    {red_in, green_in, blue_in} = 3'b111;
    repeat (300) @(negedge clk);
    {red_in, green_in, blue_in} = 3'b000;
    repeat (300) @(negedge clk);
    async_reset();
    for (int s = 0; s < 60; s++) begin
      {red_in, green_in, blue_in} = 3'($urandom);
      enable = $urandom_range(0, 7) != 0;
      repeat ($urandom_range(1, 60)) @(negedge clk);
      if (s == 30) async_reset();
    end
    enable = 1'b1;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
